// File: rtl/simplerisc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | simplerisc_pkg : SimpleRisc opcodes, immediate modifiers, IF/OF latch types |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package simplerisc_pkg;

  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  localparam logic [31:0] SR_NOP_WORD = 32'h6800_0000;
  localparam logic [3:0]  REG_RA      = 4'd15;

  localparam logic [1:0] MOD_SEXT = 2'b00;
  localparam logic [1:0] MOD_ZEXT = 2'b01;
  localparam logic [1:0] MOD_HIGH = 2'b10;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } latch_state_e;

  typedef struct packed {
    logic [4:0]  opcode;
    logic        is_imm;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [31:0] imm;
    logic [31:0] target;
  } predecode_t;

endpackage
`default_nettype wire

// File: rtl/simplerisc_predecode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | simplerisc_predecode : combinational field, immediate and target decode    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module simplerisc_predecode
  import simplerisc_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] pc_i,
  output predecode_t  dec_o
);

  always_comb begin
    dec_o        = '0;
    dec_o.opcode = word_i[31:27];
    dec_o.is_imm = word_i[26];
    dec_o.rd     = word_i[25:22];
    // ret reads ra; st reads its data register from the rd slot
    dec_o.rs1    = (word_i[31:27] == OP_RET) ? REG_RA : word_i[21:18];
    dec_o.rs2    = (word_i[31:27] == OP_ST) ? word_i[25:22] : word_i[17:14];

    case (word_i[17:16])
      MOD_ZEXT: dec_o.imm = {16'h0000, word_i[15:0]};
      MOD_HIGH: dec_o.imm = {word_i[15:0], 16'h0000};
      default:  dec_o.imm = {{16{word_i[15]}}, word_i[15:0]};
    endcase

    dec_o.target = pc_i + {{3{word_i[26]}}, word_i[26:0], 2'b00};
  end

endmodule
`default_nettype wire

// File: rtl/if_of_latch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | if_of_latch : IF/OF pipeline latch with stall hold, branch squash, predecode|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module if_of_latch
  import simplerisc_pkg::*;
#(
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter logic [31:0] NOP_WORD    = SR_NOP_WORD
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instruction,
  input  logic [31:0] PC_Current,
  input  logic        IF_Valid,
  input  logic        Stall,
  input  logic        IsBranchTaken,
  output logic [31:0] OF_Instruction,
  output logic [31:0] OF_PC,
  output logic        OF_Valid,
  output logic [4:0]  OF_Opcode,
  output logic        OF_IsImm,
  output logic [3:0]  OF_Rd,
  output logic [3:0]  OF_Rs1,
  output logic [3:0]  OF_Rs2,
  output logic [31:0] OF_Imm,
  output logic [31:0] OF_BranchTarget,
  output logic [15:0] Bubble_Count
);

  localparam logic [1:0] CNT_INIT = 2'(FLUSH_DEPTH - 1);

  latch_state_e state_q;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_dec_d;
  logic [31:0]  instr_q;
  logic [31:0]  pc_q;
  logic         valid_q;
  predecode_t   dec_q;
  logic [15:0]  bubble_q;

  logic         nop_d;
  logic         load_d;
  logic [31:0]  word_d;
  logic [31:0]  pc_d;
  predecode_t   dec_d;
  logic [15:0]  bubble_d;

  // Reset is folded into the decode input so the reset image is the nop's decode at PC 0
  assign nop_d     = Reset | IsBranchTaken | (state_q == ST_SQUASH) | ~IF_Valid;
  assign load_d    = IsBranchTaken | ~Stall;
  assign word_d    = nop_d ? NOP_WORD : Instruction;
  assign pc_d      = Reset ? 32'h0 : PC_Current;
  assign bubble_d  = (nop_d && (bubble_q != 16'hFFFF)) ? bubble_q + 16'd1 : bubble_q;
  assign cnt_dec_d = cnt_q - 2'd1;

  simplerisc_predecode u_predecode (
    .word_i (word_d),
    .pc_i   (pc_d),
    .dec_o  (dec_d)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_RUN;
      cnt_q    <= 2'd0;
      instr_q  <= NOP_WORD;
      pc_q     <= 32'h0;
      valid_q  <= 1'b0;
      dec_q    <= dec_d;
      bubble_q <= 16'h0000;
    end else begin
      if (load_d) begin
        instr_q  <= word_d;
        pc_q     <= pc_d;
        valid_q  <= ~nop_d;
        dec_q    <= dec_d;
        bubble_q <= bubble_d;
      end
      if (IsBranchTaken) begin
        cnt_q   <= CNT_INIT;
        state_q <= (CNT_INIT == 2'd0) ? ST_RUN : ST_SQUASH;
      end else if (!Stall && (state_q == ST_SQUASH)) begin
        cnt_q   <= cnt_dec_d;
        state_q <= (cnt_dec_d == 2'd0) ? ST_RUN : ST_SQUASH;
      end
    end
  end

  assign OF_Instruction  = instr_q;
  assign OF_PC           = pc_q;
  assign OF_Valid        = valid_q;
  assign OF_Opcode       = dec_q.opcode;
  assign OF_IsImm        = dec_q.is_imm;
  assign OF_Rd           = dec_q.rd;
  assign OF_Rs1          = dec_q.rs1;
  assign OF_Rs2          = dec_q.rs2;
  assign OF_Imm          = dec_q.imm;
  assign OF_BranchTarget = dec_q.target;
  assign Bubble_Count    = bubble_q;

endmodule
`default_nettype wire

// File: tb/tb_if_of_latch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_if_of_latch : directed and random checks against a behavioural model    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_if_of_latch;

  localparam int          FLUSH_DEPTH = 2;
  localparam logic [31:0] NOP         = 32'h6800_0000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Instruction = 32'h0;
  logic [31:0] PC_Current = 32'h0;
  logic        IF_Valid = 1'b0;
  logic        Stall = 1'b0;
  logic        IsBranchTaken = 1'b0;
  logic [31:0] OF_Instruction, OF_PC, OF_Imm, OF_BranchTarget;
  logic        OF_Valid, OF_IsImm;
  logic [4:0]  OF_Opcode;
  logic [3:0]  OF_Rd, OF_Rs1, OF_Rs2;
  logic [15:0] Bubble_Count;

  int checks = 0;
  int errors = 0;

  // Model: what the latch should hold, as seen from the outside
  logic [31:0] m_word = NOP;
  logic [31:0] m_pc = 32'h0;
  logic        m_valid = 1'b0;
  logic        m_pc_known = 1'b1;
  int          m_bub = 0;
  int          m_left = 0;

  if_of_latch #(.FLUSH_DEPTH(FLUSH_DEPTH), .NOP_WORD(NOP)) dut (
    .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .PC_Current(PC_Current),
    .IF_Valid(IF_Valid), .Stall(Stall), .IsBranchTaken(IsBranchTaken),
    .OF_Instruction(OF_Instruction), .OF_PC(OF_PC), .OF_Valid(OF_Valid),
    .OF_Opcode(OF_Opcode), .OF_IsImm(OF_IsImm), .OF_Rd(OF_Rd), .OF_Rs1(OF_Rs1),
    .OF_Rs2(OF_Rs2), .OF_Imm(OF_Imm), .OF_BranchTarget(OF_BranchTarget),
    .Bubble_Count(Bubble_Count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bump();
    if (m_bub < 65535) m_bub++;
  endtask

  task automatic model(input logic rst, br, st, ifv, input logic [31:0] w, pc);
    if (rst) begin
      m_word = NOP; m_pc = 32'h0; m_valid = 1'b0; m_pc_known = 1'b1; m_bub = 0; m_left = 0;
    end else if (br) begin
      m_word = NOP; m_valid = 1'b0; m_pc_known = 1'b0; m_left = FLUSH_DEPTH - 1; bump();
    end else if (!st) begin
      if (m_left > 0 || !ifv) begin
        m_word = NOP; m_valid = 1'b0; m_pc_known = 1'b0; bump();
        if (m_left > 0) m_left--;
      end else begin
        m_word = w; m_pc = pc; m_valid = 1'b1; m_pc_known = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [4:0]  op;
    logic [3:0]  rs1, rs2;
    logic [31:0] imm, tgt;
    op  = m_word[31:27];
    rs1 = (op == 5'b10100) ? 4'd15 : m_word[21:18];
    rs2 = (op == 5'b01111) ? m_word[25:22] : m_word[17:14];
    case (m_word[17:16])
      2'b01:   imm = 32'(m_word[15:0]);
      2'b10:   imm = 32'(m_word[15:0]) * 32'd65536;
      default: imm = m_word[15] ? 32'(m_word[15:0]) - 32'd65536 : 32'(m_word[15:0]);
    endcase
    tgt = m_pc + 32'($signed(m_word[26:0])) * 32'd4;
    chk({tag, ".instr"}, OF_Instruction, m_word);
    chk({tag, ".valid"}, 32'(OF_Valid), 32'(m_valid));
    chk({tag, ".opcode"}, 32'(OF_Opcode), 32'(op));
    chk({tag, ".isimm"}, 32'(OF_IsImm), 32'(m_word[26]));
    chk({tag, ".rd"}, 32'(OF_Rd), 32'(m_word[25:22]));
    chk({tag, ".rs1"}, 32'(OF_Rs1), 32'(rs1));
    chk({tag, ".rs2"}, 32'(OF_Rs2), 32'(rs2));
    chk({tag, ".imm"}, OF_Imm, imm);
    chk({tag, ".bubbles"}, 32'(Bubble_Count), 32'(m_bub));
    if (m_pc_known) begin
      chk({tag, ".pc"}, OF_PC, m_pc);
      chk({tag, ".target"}, OF_BranchTarget, tgt);
    end
  endtask

  task automatic step(input logic rst, br, st, ifv, input logic [31:0] w, pc,
                      input bit do_chk, input string tag);
    Reset = rst; IsBranchTaken = br; Stall = st; IF_Valid = ifv;
    Instruction = w; PC_Current = pc;
    @(posedge Clk);
    model(rst, br, st, ifv, w, pc);
    #1;
    if (do_chk) check_all(tag);
  endtask

  initial begin
    logic [31:0] w, pc;
    logic [4:0]  ops [4];
    int          b0;
    ops[0] = 5'b10100; ops[1] = 5'b01111; ops[2] = 5'b01001; ops[3] = 5'b10010;

    // Reset image
    step(1, 0, 0, 0, 32'hDEAD_BEEF, 32'h1234_5678, 1, "reset");
    chk("reset.opcode_nop", 32'(OF_Opcode), 32'h0D);

    // mov r2, #10
    step(0, 0, 0, 1, 32'h4C80_000A, 32'h0, 1, "mov");
    chk("mov.valid1", 32'(OF_Valid), 32'h1);
    chk("mov.rd2", 32'(OF_Rd), 32'h2);
    chk("mov.imm10", OF_Imm, 32'h0000_000A);

    // Immediate modifiers
    step(0, 0, 0, 1, 32'h4C02_1234, 32'h4, 1, "imm_hi");
    chk("imm_hi.value", OF_Imm, 32'h1234_0000);
    step(0, 0, 0, 1, 32'h4C00_8000, 32'h8, 1, "imm_sext");
    chk("imm_sext.value", OF_Imm, 32'hFFFF_8000);
    step(0, 0, 0, 1, 32'h4C01_8000, 32'hC, 1, "imm_zext");
    chk("imm_zext.value", OF_Imm, 32'h0000_8000);

    // Branch targets, including wrap-around
    step(0, 0, 0, 1, {5'b10010, 27'h7FF_FFFE}, 32'h100, 1, "b_back");
    chk("b_back.target", OF_BranchTarget, 32'h0000_00F8);
    step(0, 0, 0, 1, {5'b10010, 27'h000_0001}, 32'hFFFF_FFFC, 1, "b_wrap");
    chk("b_wrap.target", OF_BranchTarget, 32'h0000_0000);

    // ret / st register remapping
    step(0, 0, 0, 1, {5'b10100, 27'h0AB_CDEF}, 32'h20, 1, "ret");
    chk("ret.rs1", 32'(OF_Rs1), 32'hF);
    step(0, 0, 0, 1, {5'b01111, 1'b1, 4'd7, 4'd3, 18'h0_0010}, 32'h24, 1, "st");
    chk("st.rs2", 32'(OF_Rs2), 32'h7);

    // Taken branch squashes FLUSH_DEPTH loads
    b0 = m_bub;
    step(0, 1, 0, 1, 32'h4C80_0001, 32'h30, 1, "br0");
    chk("br0.valid", 32'(OF_Valid), 32'h0);
    step(0, 0, 0, 1, 32'h4C80_0002, 32'h34, 1, "br1");
    chk("br1.instr_nop", OF_Instruction, NOP);
    step(0, 0, 0, 1, 32'h4C80_0003, 32'h38, 1, "br2");
    chk("br2.instr_loaded", OF_Instruction, 32'h4C80_0003);
    chk("br2.bubbles_plus2", 32'(Bubble_Count), 32'(b0 + 2));

    // Stall freezes outputs while inputs change
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, $urandom, $urandom, 1, "stall");
    chk("stall.frozen", OF_Instruction, 32'h4C80_0003);
    // Stall and branch together: branch wins
    step(0, 1, 1, 1, 32'h4C80_0004, 32'h40, 1, "stall_br");
    chk("stall_br.valid", 32'(OF_Valid), 32'h0);

    // Reset while squashing
    step(0, 1, 0, 1, 32'h4C80_0005, 32'h44, 1, "pre_rst");
    step(1, 0, 0, 1, 32'h4C80_0006, 32'h48, 1, "rst_squash");
    step(0, 0, 0, 1, 32'h4C80_0007, 32'h4C, 1, "post_rst");
    chk("post_rst.valid_run", 32'(OF_Valid), 32'h1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 0) w[31:27] = ops[$urandom_range(0, 3)];
      pc = $urandom;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) != 0), w, pc, 1, "rand");
    end

    // Bubble counter saturation
    step(1, 0, 0, 0, 32'h0, 32'h0, 1, "sat_rst");
    for (int i = 0; i < 70000; i++) step(0, 0, 0, 0, 32'h4C80_0001, 32'h0, 0, "sat");
    check_all("sat");
    chk("sat.ffff", 32'(Bubble_Count), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_of_latch.md
IF_OF_LATCH -- requirements
Module: if_of_latch

Interface
REQ-001 SHALL have parameter FLUSH_DEPTH, default 2, number of wrong-path fetches squashed after a taken branch (1..3).
REQ-002 SHALL have parameter NOP_WORD, default 32'h6800_0000, SimpleRisc nop encoding (opcode 01101).
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Instruction  input  32  fetched word from IF stage.
REQ-006 SHALL have port PC_Current  input  32  byte address of Instruction.
REQ-007 SHALL have port IF_Valid  input  1  Instruction/PC_Current meaningful this cycle.
REQ-008 SHALL have port Stall  input  1  downstream hazard; hold latch contents.
REQ-009 SHALL have port IsBranchTaken  input  1  branch resolved taken; squash younger instructions.
REQ-010 SHALL have ports OF_Instruction, OF_PC  output  32 each  latched word and its PC.
REQ-011 SHALL have port OF_Valid  output  1  latched entry is a real (non-squashed) instruction.
REQ-012 SHALL have ports OF_Opcode  output  5; OF_IsImm  output  1; OF_Rd, OF_Rs1, OF_Rs2  output  4 each; predecoded fields.
REQ-013 SHALL have ports OF_Imm  output  32 and OF_BranchTarget  output  32  predecoded immediate and target.
REQ-014 SHALL have port Bubble_Count  output  16  saturating count of squashed/bubble cycles.

Function
REQ-015 SHALL be a FSM with states RUN, SQUASH; latch loads on every posedge where not held.
REQ-016 Priority SHALL be Reset > IsBranchTaken > Stall > normal load.
REQ-017 RUN, no stall/branch: SHALL load Instruction/PC_Current, OF_Valid <= IF_Valid; IF_Valid=0 loads NOP_WORD, OF_Valid=0.
REQ-018 Stall=1 (no branch): all outputs SHALL hold; state and squash counter SHALL hold.
REQ-019 IsBranchTaken=1 in any state, even with Stall=1: SHALL load NOP_WORD, OF_Valid=0, enter SQUASH with counter = FLUSH_DEPTH-1.
REQ-020 SQUASH: each unstalled cycle SHALL load NOP_WORD, OF_Valid=0, decrement counter; at counter 0 return to RUN (next load is normal); FLUSH_DEPTH=1 returns to RUN immediately.
REQ-021 IsBranchTaken during SQUASH SHALL restart counter at FLUSH_DEPTH-1.
REQ-022 Predecode SHALL be registered with the word: Opcode=[31:27], IsImm=[26], Rd=[25:22], Rs1=[21:18], Rs2=[17:14].
REQ-023 Rs1 SHALL be 4'd15 (ra) when opcode=10100 (ret); Rs2 SHALL be [25:22] when opcode=01111 (st).
REQ-024 OF_Imm: modifier [17:16]=00 sign-extend [15:0]; 01 zero-extend; 10 {[15:0],16'h0}; 11 treated as 00.
REQ-025 OF_BranchTarget SHALL equal PC + (sign-extend([26:0]) << 2), mod 2^32 wrap.
REQ-026 Bubble_Count SHALL increment on each posedge where OF_Valid is loaded 0 (squash or IF_Valid=0, not stall holds) and saturate at 16'hFFFF.
REQ-027 Outputs SHALL be driven only from registers; no combinational input-to-output path.

Reset
REQ-028 Reset SHALL set OF_Instruction=NOP_WORD, OF_PC=0, OF_Valid=0, OF_Opcode=5'b01101, OF_IsImm=0, Rd/Rs1/Rs2=0, OF_Imm=0, OF_BranchTarget=0, Bubble_Count=0, state RUN, counter 0.
REQ-029 Reset mid-SQUASH or mid-stall SHALL take effect at the same posedge, overriding all other inputs.

Structure
REQ-030 Opcode constants (nop, ret, st, b/beq/bgt/call), NOP_WORD, modifier codes and FSM state encodings SHALL live in shared package simplerisc_pkg.
REQ-031 Predecode SHALL be a combinational sub-module simplerisc_predecode (word, PC in; fields, imm, target out), reused by later stages.

Verification
REQ-032 Reset then Instruction=32'h4C80_000A (mov r2, #10), PC=0x0, IF_Valid=1 -> next edge OF_Valid=1, Opcode=01001, IsImm=1, Rd=2, OF_Imm=0x0000000A.
REQ-033 Load imm [17:16]=10, [15:0]=0x1234 -> OF_Imm=0x1234_0000; [17:16]=00, 0x8000 -> 0xFFFF_8000; 01, 0x8000 -> 0x0000_8000.
REQ-034 PC=0x100, b with offset 27'h7FF_FFFE (-2) -> OF_BranchTarget=0xF8; PC=0xFFFF_FFFC, offset 1 -> 0x0.
REQ-035 IsBranchTaken=1 with FLUSH_DEPTH=2, valid inputs -> two edges OF_Valid=0 with NOP_WORD, third edge loads input; Bubble_Count +2.
REQ-036 Stall=1 for 3 cycles with changing inputs -> outputs frozen, Bubble_Count unchanged; Stall+IsBranchTaken same cycle -> squash wins.
REQ-037 Reset asserted during SQUASH -> next edge reset values, state RUN; 70000 bubble cycles -> Bubble_Count=0xFFFF.
